// File: rtl/act_lut_fetch.sv
// Activation-table fetch stage: splits a signed fixed-point sample into a table index
// and a fraction, then returns the two neighbouring entries through a 2-stage valid/ready pipe.
module act_lut_fetch #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     wr_en,
    input  logic [DATA_W-FRAC_W-1:0] wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] base,
    output logic signed [DATA_W-1:0] next_data,
    output logic [DATA_W-1:0]        remaining,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int IDX_W   = DATA_W - FRAC_W;
    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(1) << (IDX_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    // Offsetting the integer part by half the table is the same as flipping its sign bit.
    function automatic logic [IDX_W-1:0] f_index(input logic signed [DATA_W-1:0] x);
        logic [IDX_W-1:0] hi;
        hi = x[DATA_W-1:FRAC_W];
        return hi ^ IDX_HALF;
    endfunction

    function automatic logic [IDX_W-1:0] f_sat_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? idx : idx + IDX_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] f_zext_frac(input logic [FRAC_W-1:0] frac);
        return {{(DATA_W-FRAC_W){1'b0}}, frac};
    endfunction

    logic signed [DATA_W-1:0] r_table [ENTRIES];

    logic                     r_vld_p1;
    logic [IDX_W-1:0]         r_idx_p1;
    logic [IDX_W-1:0]         r_nidx_p1;
    logic [FRAC_W-1:0]        r_frac_p1;

    logic                     r_vld_p2;
    logic signed [DATA_W-1:0] r_base_p2;
    logic signed [DATA_W-1:0] r_next_p2;
    logic [DATA_W-1:0]        r_rem_p2;

    logic w_adv1;
    logic w_adv2;
    logic w_in_xfer;

    assign w_adv2    = !r_vld_p2 || out_ready;
    assign w_adv1    = !r_vld_p1 || w_adv2;
    assign w_in_xfer = in_valid && w_adv1;
    assign in_ready  = w_adv1;

    // Stage-2 reads below sample the table before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '0;
            end
        end else if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // Stage 1: index split
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv1) begin
            r_vld_p1 <= w_in_xfer;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv1) begin
            r_idx_p1  <= f_index(in_x);
            r_nidx_p1 <= f_sat_next(f_index(in_x));
            r_frac_p1 <= in_x[FRAC_W-1:0];
        end
    end

    // Stage 2: table fetch into output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_base_p2 <= '0;
            r_next_p2 <= '0;
            r_rem_p2  <= '0;
        end else if (w_adv2) begin
            r_vld_p2  <= r_vld_p1;
            r_base_p2 <= r_table[r_idx_p1];
            r_next_p2 <= r_table[r_nidx_p1];
            r_rem_p2  <= f_zext_frac(r_frac_p1);
        end
    end

    assign out_valid = r_vld_p2;
    assign base      = r_base_p2;
    assign next_data = r_next_p2;
    assign remaining = r_rem_p2;

endmodule

// File: tb/tb_act_lut_fetch.sv
// Bench for act_lut_fetch: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level lookup model.
module tb_act_lut_fetch;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] in_x;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic signed [7:0] wr_data;
    logic signed [7:0] base;
    logic signed [7:0] next_data;
    logic [7:0]        remaining;
    logic              out_valid;
    logic              out_ready;

    int checks   = 0;
    int failures = 0;
    int model_tab [16];

    typedef struct {
        logic [7:0] x;
        int         b;
        int         n;
        int         r;
    } vec_t;

    typedef struct {
        int b;
        int n;
        int r;
    } exp_t;

    vec_t vecs [7];
    exp_t q [$];

    act_lut_fetch #(.DATA_W(8), .FRAC_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_x      (in_x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .base      (base),
        .next_data (next_data),
        .remaining (remaining),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic signed [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en = 1'b0;
        model_tab[a] = int'(d);
    endtask

    task automatic setup_table();
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 8'(4 * i));
        end
    endtask

    // Reference lookup: floor-divide by 16 for the integer part, offset by 8 into the table.
    function automatic exp_t model(input logic [7:0] x);
        exp_t e;
        int xi;
        int ip;
        int idx;
        int nidx;
        xi = int'($signed(x));
        ip = xi / 16;
        if (xi < 0 && (xi % 16) != 0) ip = ip - 1;
        idx  = ip + 8;
        nidx = (idx == 15) ? 15 : idx + 1;
        e.b = model_tab[idx];
        e.n = model_tab[nidx];
        e.r = xi - 16 * ip;
        return e;
    endfunction

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_spurious_valid"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({tag, "_base"}, int'(base), e.b);
            chk({tag, "_next"}, int'(next_data), e.n);
            chk({tag, "_rem"}, int'(remaining), e.r);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_x      = '0;
        in_valid  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) model_tab[i] = 0;

        vecs[0] = '{8'h00, 32, 36, 0};
        vecs[1] = '{8'h25, 40, 44, 5};
        vecs[2] = '{8'h7F, 60, 60, 15};
        vecs[3] = '{8'h80, 0, 4, 0};
        vecs[4] = '{8'h70, 60, 60, 0};
        vecs[5] = '{8'hF3, 28, 32, 3};
        vecs[6] = '{8'h08, 32, 36, 8};

        cyc();
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_base", int'(base), 0);
        chk("rst_next", int'(next_data), 0);
        chk("rst_rem", int'(remaining), 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        cyc();
        setup_table();

        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_x     = vecs[i].x;
            #1;
            chk("vec_in_ready", in_ready, 1);
            cyc();
            in_valid = 1'b0;
            #1;
            chk("vec_lat1_valid", out_valid, 0);
            cyc();
            chk("vec_valid", out_valid, 1);
            chk("vec_base", int'(base), vecs[i].b);
            chk("vec_next", int'(next_data), vecs[i].n);
            chk("vec_rem", int'(remaining), vecs[i].r);
            cyc();
        end

        // Backpressure: two accepted, third held at the input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 8'h00;
        #1;
        chk("bp_rdy0", in_ready, 1);
        cyc();
        in_x = 8'h10;
        #1;
        chk("bp_rdy1", in_ready, 1);
        cyc();
        in_x = 8'h20;
        #1;
        chk("bp_rdy_full", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_hold_base0", int'(base), 32);
        cyc();
        chk("bp_rdy_full2", in_ready, 0);
        chk("bp_hold_base1", int'(base), 32);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("bp_out1_valid", out_valid, 1);
        chk("bp_out1_base", int'(base), 36);
        cyc();
        chk("bp_out2_valid", out_valid, 1);
        chk("bp_out2_base", int'(base), 40);
        cyc();
        chk("bp_empty", out_valid, 0);

        // Write to entry 9 on the edge where the idx-8 sample reads it.
        in_valid = 1'b1;
        in_x     = 8'h00;
        cyc();
        in_x    = 8'h10;
        wr_en   = 1'b1;
        wr_addr = 4'd9;
        wr_data = 8'sd100;
        cyc();
        model_tab[9] = 100;
        wr_en    = 1'b0;
        in_valid = 1'b0;
        chk("hz_valid0", out_valid, 1);
        chk("hz_base0", int'(base), 32);
        chk("hz_next_old", int'(next_data), 36);
        cyc();
        chk("hz_valid1", out_valid, 1);
        chk("hz_base_new", int'(base), 100);
        chk("hz_next1", int'(next_data), 40);
        cyc();

        // Randomized traffic with a fresh random table.
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 8'($urandom));
        end
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_x      = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            chk("rnd_in_ready", in_ready, (q.size() == 2 && !out_ready) ? 0 : 1);
            if (q.size() == 0) chk("rnd_idle_valid", out_valid, 0);
            if (out_valid && out_ready) pop_and_check("rnd");
            if (in_valid && in_ready) q.push_back(model(in_x));
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid) pop_and_check("drain");
            cyc();
        end
        chk("rnd_drain_empty", q.size(), 0);

        // Reset with two samples in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 8'h00;
        cyc();
        in_x = 8'h10;
        cyc();
        in_valid = 1'b0;
        chk("mr_pre_valid", out_valid, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_base", int'(base), 0);
        cyc();
        chk("mr_no_ghost", out_valid, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = 8'h00;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("mr_valid", out_valid, 1);
        chk("mr_base_cleared", int'(base), 0);
        chk("mr_next_cleared", int'(next_data), 0);
        cyc();
        chk("mr_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
